// File: rtl/miner_pkg.sv
// Shared types and defaults for the miner job scheduler.
// Defaults describe a 32-bit nonce space hashed as double SHA-256.
package miner_pkg;

  localparam int DEF_NONCE_W = 32;
  localparam int DEF_PHASES  = 2;
  localparam int DEF_PHASE_W = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_REPORT,
    S_NEXT
  } state_t;

endpackage

// File: rtl/nonce_range_counter.sv
// Nonce range counter: load captures start and inclusive end, inc steps modulo 2^W.
// Value and end-match update one cycle after load/inc; no backpressure, caller gates inc.
module nonce_range_counter #(
  parameter int W = miner_pkg::DEF_NONCE_W
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic [W-1:0] end_value,
  input  logic         inc,
  output logic [W-1:0] value,
  output logic         is_last
);

  logic [W-1:0] end_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      value <= '0;
      end_q <= '0;
    end else if (load) begin
      value <= load_value;
      end_q <= end_value;
    end else if (inc) begin
      value <= value + W'(1);
    end
  end

  assign is_last = (value == end_q);

endmodule

// File: rtl/nonce_sweep_ctrl.sv
// Sweeps a nonce range, launching PHASES chained core passes per nonce and reporting hits.
// Accept to first core_start is 1 cycle; a found nonce stalls the sweep until found_ready.
module nonce_sweep_ctrl
  import miner_pkg::*;
#(
  parameter int NONCE_W = DEF_NONCE_W,
  parameter int PHASES  = DEF_PHASES,
  parameter int PHASE_W = DEF_PHASE_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               job_valid,
  output logic               job_ready,
  input  logic [NONCE_W-1:0] job_nonce_start,
  input  logic [NONCE_W-1:0] job_nonce_end,
  input  logic               abort,
  output logic               core_start,
  output logic [PHASE_W-1:0] core_phase,
  output logic [NONCE_W-1:0] core_nonce,
  input  logic               core_done,
  input  logic               core_hit,
  output logic               found_valid,
  input  logic               found_ready,
  output logic [NONCE_W-1:0] found_nonce,
  output logic               busy,
  output logic               job_done,
  output logic [NONCE_W:0]   tried_count
);

  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(PHASES - 1);

  state_t             state, state_nxt;
  logic [PHASE_W-1:0] phase;
  logic               is_last, kill;
  logic               accept, phase_adv, report_set, report_clr;
  logic               count_inc, nonce_inc, done_set;

  nonce_range_counter #(.W(NONCE_W)) u_range (
    .clock      (clock),
    .reset      (reset),
    .load       (accept),
    .load_value (job_nonce_start),
    .end_value  (job_nonce_end),
    .inc        (nonce_inc),
    .value      (core_nonce),
    .is_last    (is_last)
  );

  assign job_ready  = (state == S_IDLE);
  assign busy       = !job_ready;
  assign core_start = (state == S_LAUNCH);
  assign core_phase = phase;
  assign kill       = abort && (state != S_IDLE);

  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    phase_adv  = 1'b0;
    report_set = 1'b0;
    report_clr = 1'b0;
    count_inc  = 1'b0;
    nonce_inc  = 1'b0;
    done_set   = 1'b0;
    unique case (state)
      S_IDLE: if (job_valid) begin
        accept    = 1'b1;
        state_nxt = S_LAUNCH;
      end
      S_LAUNCH: state_nxt = S_WAIT;
      S_WAIT: if (core_done) begin
        if (phase < LAST_PHASE) begin
          phase_adv = 1'b1;
          state_nxt = S_LAUNCH;
        end else if (core_hit) begin
          report_set = 1'b1;
          state_nxt  = S_REPORT;
        end else begin
          state_nxt = S_NEXT;
        end
      end
      S_REPORT: if (found_ready) begin
        report_clr = 1'b1;
        state_nxt  = S_NEXT;
      end
      S_NEXT: begin
        count_inc = 1'b1;
        if (is_last) begin
          done_set  = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          nonce_inc = 1'b1;
          state_nxt = S_LAUNCH;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    // Abort overrides everything; nonce and count are left for diagnostics.
    if (kill) begin
      phase_adv  = 1'b0;
      report_set = 1'b0;
      report_clr = 1'b0;
      count_inc  = 1'b0;
      nonce_inc  = 1'b0;
      done_set   = 1'b0;
      state_nxt  = S_IDLE;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= S_IDLE;
      phase       <= '0;
      found_nonce <= '0;
      found_valid <= 1'b0;
      tried_count <= '0;
      job_done    <= 1'b0;
    end else begin
      state    <= state_nxt;
      job_done <= done_set;
      if (accept || nonce_inc) phase <= '0;
      else if (phase_adv)      phase <= phase + PHASE_W'(1);
      if (accept)         tried_count <= '0;
      else if (count_inc) tried_count <= tried_count + (NONCE_W+1)'(1);
      if (report_set) begin
        found_nonce <= core_nonce;
        found_valid <= 1'b1;
      end else if (report_clr || kill) begin
        found_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_nonce_sweep_ctrl.sv
// Bench for nonce_sweep_ctrl: table and random jobs against a range-walk model,
// plus directed back-pressure, abort, reset and single-pass corner cases.
module tb_nonce_sweep_ctrl;
  localparam int NW     = 32;
  localparam int PHASES = 2;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset = 1'b0, job_valid = 1'b0, abort = 1'b0;
  logic core_done = 1'b0, core_hit = 1'b0, found_ready = 1'b0;
  logic [NW-1:0] job_nonce_start = '0, job_nonce_end = '0;
  logic job_ready, core_start, found_valid, busy, job_done;
  logic [1:0] core_phase;
  logic [NW-1:0] core_nonce, found_nonce;
  logic [NW:0] tried_count;

  logic job_valid1 = 1'b0, abort1 = 1'b0, core_done1 = 1'b0, core_hit1 = 1'b0, found_ready1 = 1'b1;
  logic [NW-1:0] job_nonce_start1 = '0, job_nonce_end1 = '0;
  logic job_ready1, core_start1, found_valid1, busy1, job_done1;
  logic [1:0] core_phase1;
  logic [NW-1:0] core_nonce1, found_nonce1;
  logic [NW:0] tried_count1;

  nonce_sweep_ctrl #(.NONCE_W(NW), .PHASES(PHASES), .PHASE_W(2)) dut (
    .clock(clock), .reset(reset), .job_valid(job_valid), .job_ready(job_ready),
    .job_nonce_start(job_nonce_start), .job_nonce_end(job_nonce_end), .abort(abort),
    .core_start(core_start), .core_phase(core_phase), .core_nonce(core_nonce),
    .core_done(core_done), .core_hit(core_hit), .found_valid(found_valid),
    .found_ready(found_ready), .found_nonce(found_nonce), .busy(busy),
    .job_done(job_done), .tried_count(tried_count));

  nonce_sweep_ctrl #(.NONCE_W(NW), .PHASES(1), .PHASE_W(2)) dut1 (
    .clock(clock), .reset(reset), .job_valid(job_valid1), .job_ready(job_ready1),
    .job_nonce_start(job_nonce_start1), .job_nonce_end(job_nonce_end1), .abort(abort1),
    .core_start(core_start1), .core_phase(core_phase1), .core_nonce(core_nonce1),
    .core_done(core_done1), .core_hit(core_hit1), .found_valid(found_valid1),
    .found_ready(found_ready1), .found_nonce(found_nonce1), .busy(busy1),
    .job_done(job_done1), .tried_count(tried_count1));

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct packed { logic [1:0] ph; logic [NW-1:0] n; } start_t;
  start_t        start_log[$];
  logic [NW-1:0] found_log[$];
  int            done_cnt = 0;

  // Environment knobs: core latency, hit rule (nonce divisible by hit_mod), consumer readiness.
  bit resp_en = 1'b1, rdy_auto = 1'b1;
  int lat = 2, hit_mod = 0, rdy_pct = 100, cd = 0;
  logic [1:0] cd_phase;
  logic [NW-1:0] cd_nonce, pv_nonce;
  logic pv_valid = 1'b0, pv_ready = 1'b0, pv_abort = 1'b1;

  function automatic bit is_hit(input logic [NW-1:0] n, input int m);
    return (m != 0) && ((n % NW'(m)) == '0);
  endfunction

  initial begin
    forever begin
      @(negedge clock);
      if (rdy_auto) found_ready = ($urandom_range(0, 99) < rdy_pct);
      if (core_start) start_log.push_back('{ph: core_phase, n: core_nonce});
      if (found_valid && found_ready && !abort) found_log.push_back(found_nonce);
      if (job_done) done_cnt++;
      if (pv_valid && !pv_ready && !pv_abort) begin
        chk("report_hold_valid", 64'(found_valid), 64'(1));
        chk("report_hold_nonce", 64'(found_nonce), 64'(pv_nonce));
      end
      pv_valid = found_valid; pv_ready = found_ready; pv_nonce = found_nonce;
      pv_abort = abort || !reset;
      if (resp_en) begin
        core_done = 1'b0;
        core_hit  = 1'($urandom_range(0, 1));
        if (!reset || abort) cd = 0;
        else if (cd > 0) begin
          cd--;
          if (cd == 0) begin
            core_done = 1'b1;
            if (int'(cd_phase) == PHASES - 1) core_hit = is_hit(cd_nonce, hit_mod);
          end
        end
        if (core_start) begin
          cd = lat; cd_phase = core_phase; cd_nonce = core_nonce;
        end
      end
    end
  end

  // Called at posedge+#1 with dut idle; offers the job right away.
  task automatic run_job(input logic [NW-1:0] s, input logic [NW-1:0] e, input int l,
                         input int hm, input int rp, input int exp_tried, input int exp_hits);
    start_t        exp_st[$];
    logic [NW-1:0] exp_f[$];
    logic [NW-1:0] n;
    int k, d0, cyc;
    n = s; k = 0;
    forever begin
      for (int p = 0; p < PHASES; p++) exp_st.push_back('{ph: 2'(p), n: n});
      if (is_hit(n, hm)) exp_f.push_back(n);
      k++;
      if (n == e) break;
      n = n + 1'b1;
    end
    lat = l; hit_mod = hm; rdy_pct = rp;
    start_log.delete(); found_log.delete(); d0 = done_cnt;
    job_valid = 1'b1; job_nonce_start = s; job_nonce_end = e;
    @(posedge clock); #1;
    job_valid = 1'b0; job_nonce_start = $urandom; job_nonce_end = $urandom;
    chk("first_launch", 64'(core_start), 64'(1));
    cyc = 0;
    while (done_cnt == d0 && cyc < 5000) begin @(posedge clock); cyc++; end
    #1;
    chk("job_done_seen", 64'(done_cnt != d0), 64'(1));
    chk("idle_ready", 64'(job_ready), 64'(1));
    chk("idle_busy", 64'(busy), 64'(0));
    chk("tried", 64'(tried_count), 64'(k));
    if (exp_tried >= 0) chk("tried_tab", 64'(tried_count), 64'(exp_tried));
    chk("start_cnt", 64'(start_log.size()), 64'(exp_st.size()));
    for (int i = 0; i < start_log.size() && i < exp_st.size(); i++)
      chk("start_seq", 64'(start_log[i]), 64'(exp_st[i]));
    chk("found_cnt", 64'(found_log.size()), 64'(exp_f.size()));
    if (exp_hits >= 0) chk("found_tab", 64'(found_log.size()), 64'(exp_hits));
    for (int i = 0; i < found_log.size() && i < exp_f.size(); i++)
      chk("found_seq", 64'(found_log[i]), 64'(exp_f[i]));
    repeat (3) @(posedge clock);
    #1;
    chk("one_job_done", 64'(done_cnt - d0), 64'(1));
  endtask

  typedef struct {
    logic [NW-1:0] s, e;
    int lat, hm, rp, tried, hits;
  } vec_t;
  vec_t tab[6];

  initial begin
    int c, d0, fl0;
    logic [NW-1:0] s;
    tab[0] = '{32'd5,        32'd7,        3, 0, 100, 3, 0};
    tab[1] = '{32'h10,       32'h10,       2, 1,  50, 1, 1};
    tab[2] = '{32'hFFFFFFFE, 32'h00000001, 1, 0, 100, 4, 0};
    tab[3] = '{32'd8,        32'd15,       1, 4,  70, 8, 2};
    tab[4] = '{32'hFFFFFFFD, 32'd2,        2, 2,  40, 6, 3};
    tab[5] = '{32'd0,        32'd5,        4, 3, 100, 6, 2};

    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    chk("rst_job_ready", 64'(job_ready), 64'(1));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_core_start", 64'(core_start), 64'(0));
    chk("rst_found_valid", 64'(found_valid), 64'(0));
    chk("rst_job_done", 64'(job_done), 64'(0));
    chk("rst_tried", 64'(tried_count), 64'(0));
    chk("rst_core_nonce", 64'(core_nonce), 64'(0));
    chk("rst_found_nonce", 64'(found_nonce), 64'(0));
    chk("rst_ready1", 64'(job_ready1), 64'(1));

    foreach (tab[i]) run_job(tab[i].s, tab[i].e, tab[i].lat, tab[i].hm, tab[i].rp, tab[i].tried, tab[i].hits);

    for (int j = 0; j < 25; j++) begin
      s = $urandom;
      if ($urandom_range(0, 2) == 0) s = 32'hFFFFFFFF - NW'($urandom_range(0, 3));
      run_job(s, s + NW'($urandom_range(0, 5)), $urandom_range(1, 4),
              $urandom_range(0, 3), $urandom_range(20, 100), -1, -1);
    end

    // Hit held under back-pressure for 4 cycles, then handshake and job_done.
    rdy_auto = 1'b0; found_ready = 1'b0; lat = 2; hit_mod = 1;
    found_log.delete(); d0 = done_cnt;
    job_valid = 1'b1; job_nonce_start = 32'h10; job_nonce_end = 32'h10;
    @(posedge clock); #1 job_valid = 1'b0;
    c = 0;
    while (!found_valid && c < 100) begin @(posedge clock); #1; c++; end
    for (int i = 0; i < 4; i++) begin
      chk("bp_valid", 64'(found_valid), 64'(1));
      chk("bp_nonce", 64'(found_nonce), 64'(32'h10));
      @(posedge clock); #1;
    end
    found_ready = 1'b1;
    @(posedge clock); #1 found_ready = 1'b0;
    chk("bp_released", 64'(found_valid), 64'(0));
    @(posedge clock); #1;
    chk("bp_job_done", 64'(job_done), 64'(1));
    chk("bp_found_log", 64'(found_log.size()), 64'(1));
    chk("bp_tried", 64'(tried_count), 64'(1));
    @(posedge clock); #1;

    // Abort in WAIT coincident with core_done.
    resp_en = 1'b0; core_done = 1'b0; d0 = done_cnt;
    job_valid = 1'b1; job_nonce_start = 32'd100; job_nonce_end = 32'd200;
    @(posedge clock); #1 job_valid = 1'b0;
    chk("ab_launch", 64'(core_start), 64'(1));
    @(posedge clock); #1;
    core_done = 1'b1; core_hit = 1'b1; abort = 1'b1;
    @(posedge clock); #1;
    core_done = 1'b0; core_hit = 1'b0; abort = 1'b0;
    chk("abw_ready", 64'(job_ready), 64'(1));
    chk("abw_busy", 64'(busy), 64'(0));
    chk("abw_found", 64'(found_valid), 64'(0));
    chk("abw_nonce_kept", 64'(core_nonce), 64'(100));
    repeat (3) @(posedge clock);
    #1;
    chk("abw_no_done", 64'(done_cnt), 64'(d0));
    chk("abw_still_idle", 64'(job_ready), 64'(1));

    // Abort in REPORT with a simultaneous found_ready.
    resp_en = 1'b1; hit_mod = 1; lat = 1; found_ready = 1'b0;
    job_valid = 1'b1; job_nonce_start = 32'd50; job_nonce_end = 32'd60;
    @(posedge clock); #1 job_valid = 1'b0;
    c = 0;
    while (!found_valid && c < 100) begin @(posedge clock); #1; c++; end
    chk("abr_reported", 64'(found_valid), 64'(1));
    @(posedge clock); #1;
    fl0 = found_log.size(); d0 = done_cnt;
    abort = 1'b1; found_ready = 1'b1;
    @(posedge clock); #1 abort = 1'b0; found_ready = 1'b0;
    chk("abr_found", 64'(found_valid), 64'(0));
    chk("abr_ready", 64'(job_ready), 64'(1));
    chk("abr_tried_kept", 64'(tried_count), 64'(0));
    repeat (3) @(posedge clock);
    #1;
    chk("abr_no_done", 64'(done_cnt), 64'(d0));
    chk("abr_no_handshake", 64'(found_log.size()), 64'(fl0));
    rdy_auto = 1'b1;

    // Reset pulse mid-sweep, then an immediate new job.
    job_valid = 1'b1; job_nonce_start = 32'd1000; job_nonce_end = 32'd1100;
    lat = 2; hit_mod = 3; rdy_pct = 50;
    @(posedge clock); #1 job_valid = 1'b0;
    repeat (40) @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock); #1 reset = 1'b1;
    chk("mrst_ready", 64'(job_ready), 64'(1));
    chk("mrst_busy", 64'(busy), 64'(0));
    chk("mrst_start", 64'(core_start), 64'(0));
    chk("mrst_found_valid", 64'(found_valid), 64'(0));
    chk("mrst_job_done", 64'(job_done), 64'(0));
    chk("mrst_tried", 64'(tried_count), 64'(0));
    chk("mrst_core_nonce", 64'(core_nonce), 64'(0));
    chk("mrst_found_nonce", 64'(found_nonce), 64'(0));
    run_job(32'd3, 32'd3, 1, 0, 100, 1, 0);

    // Single-pass build: one start per nonce, stray done in IDLE ignored.
    job_valid1 = 1'b1; job_nonce_start1 = 32'd20; job_nonce_end1 = 32'd22;
    @(posedge clock); #1 job_valid1 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      c = 0;
      while (!core_start1 && c < 20) begin @(posedge clock); #1; c++; end
      chk("p1_start", 64'(core_start1), 64'(1));
      chk("p1_phase", 64'(core_phase1), 64'(0));
      chk("p1_nonce", 64'(core_nonce1), 64'(20 + k));
      @(posedge clock); #1;
      @(posedge clock); #1 core_done1 = 1'b1;
      @(posedge clock); #1 core_done1 = 1'b0;
    end
    @(posedge clock); #1;
    chk("p1_job_done", 64'(job_done1), 64'(1));
    chk("p1_tried", 64'(tried_count1), 64'(3));
    core_done1 = 1'b1; core_hit1 = 1'b1;
    @(posedge clock); #1 core_done1 = 1'b0; core_hit1 = 1'b0;
    chk("p1_stray_ready", 64'(job_ready1), 64'(1));
    chk("p1_stray_start", 64'(core_start1), 64'(0));
    chk("p1_stray_found", 64'(found_valid1), 64'(0));
    chk("p1_stray_tried", 64'(tried_count1), 64'(3));
    chk("p1_stray_done", 64'(job_done1), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/nonce_sweep_ctrl.md
Name: nonce_sweep_ctrl

Overview:
- Job-level scheduler for the miner's hash core.
- Accepts a nonce range, then launches the core once per chained hash pass per nonce (PHASES passes; 2 = double SHA-256).
- Collects the hit flag after the last pass and reports winning nonces over a valid/ready port.
- Sits between the host/UART job interface and the hash core; it is the only block that drives core_start.

Parameters:
NONCE_W, 32, nonce width; the range counter wraps modulo 2^NONCE_W
PHASES, 2, hash passes per nonce; legal values 1..4
PHASE_W, 2, width of core_phase; must hold PHASES-1

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-low; low on a rising edge forces reset state
job_valid  in  1  job offered
job_ready  out  1  controller idle and able to accept a job
job_nonce_start  in  NONCE_W  first nonce, sampled on accept
job_nonce_end  in  NONCE_W  last nonce inclusive, sampled on accept
abort  in  1  kill the current job
core_start  out  1  one-cycle launch pulse to the hash core
core_phase  out  PHASE_W  pass index for the launched hash
core_nonce  out  NONCE_W  nonce under test; stable from LAUNCH through final core_done
core_done  in  1  one-cycle pulse: current pass finished
core_hit  in  1  target met; sampled only with core_done on pass PHASES-1
found_valid  out  1  winning nonce available
found_ready  in  1  consumer takes found_nonce
found_nonce  out  NONCE_W  winning nonce
busy  out  1  state is not IDLE
job_done  out  1  one-cycle pulse: range exhausted normally
tried_count  out  NONCE_W+1  nonces completed in the current or last job

Behaviour:
- Reset (clock, reset, synchronous, active-low). While reset is low at an edge:
  - state=IDLE, phase=0.
  - core_nonce=0, found_nonce=0, tried_count=0.
  - core_start=0, found_valid=0, job_done=0.
- Combinational outputs: job_ready=(state==IDLE), busy=!job_ready. First cycle after reset: job_ready=1, busy=0.
- States: IDLE, LAUNCH, WAIT, REPORT, NEXT.
- IDLE:
  - On job_valid&&job_ready: latch end, core_nonce<=start, phase<=0, tried_count<=0, go to LAUNCH.
  - core_done/core_hit are ignored in IDLE.
- LAUNCH:
  - core_start=1 for exactly this cycle, with core_phase=phase.
  - Always go to WAIT next cycle.
  - core_done is ignored in LAUNCH; the core guarantees at least 1 cycle of latency.
- WAIT (holds indefinitely until core_done):
  - phase<PHASES-1: phase++, go to LAUNCH.
  - Final pass with core_hit=1: found_nonce<=core_nonce, found_valid<=1, go to REPORT.
  - Final pass with core_hit=0: go to NEXT.
- REPORT:
  - found_valid and found_nonce are held stable until found_ready.
  - On found_valid&&found_ready: found_valid<=0, go to NEXT.
  - The sweep stalls while the consumer back-pressures.
- NEXT (always 1 cycle):
  - tried_count++.
  - If core_nonce==end: go to IDLE and pulse job_done in the first IDLE cycle.
  - Else: core_nonce<=core_nonce+1 (mod 2^NONCE_W), phase<=0, go to LAUNCH.
- Range rules:
  - start==end: exactly one nonce.
  - end<start: the sweep wraps through all-ones to 0.
  - start=0, end=all-ones: full 2^NONCE_W sweep; tried_count ends at 2^NONCE_W, which is why it is NONCE_W+1 wide.
- Latency:
  - Accept at edge N gives core_start in cycle N+1.
  - core_done in cycle M gives the next core_start at M+1 on a phase advance, or M+2 via NEXT.
- Abort:
  - abort=1 in any non-IDLE state: next state is IDLE, found_valid<=0 (a pending report is dropped), no job_done.
  - core_nonce and tried_count keep their values for diagnostics.
  - abort wins over a simultaneous core_done or found_ready.
  - abort in IDLE is ignored.
  - abort and job_valid in the same IDLE cycle: the job is accepted.
- Reset mid-job: same as abort, plus all registers take their reset values.

Decomposition:
- Shared package (miner_pkg):
  - state enum.
  - NONCE_W default.
  - PHASE_W.
  - PHASES for double SHA-256 (2).
- Sub-module nonce_range_counter:
  - Inputs: load, load_value, end value, inc.
  - Outputs: value, is_last (value==end).
  - Wraps modulo 2^NONCE_W.
- The FSM, phase counter and found register stay in nonce_sweep_ctrl.

Test Plan:
- Basic miss: job start=5, end=7, core_done 3 cycles after each start, no hits -> 6 core_start pulses with (phase,nonce)=(0,5),(1,5),(0,6),(1,6),(0,7),(1,7); one job_done; tried_count=3; no found_valid.
- Hit with back-pressure: start=end=0x10, hit on phase 1, found_ready low for 4 cycles -> found_valid=1 and found_nonce=0x10 held for 4 cycles; handshake completes; then job_done.
- Wrap: start=0xFFFFFFFE, end=0x00000001 -> nonces FFFFFFFE, FFFFFFFF, 0, 1 in order; tried_count=4.
- Abort in WAIT coincident with core_done, and abort in REPORT -> IDLE next cycle; no job_done; found_valid=0; job_ready=1.
- Reset low mid-sweep for 1 cycle -> every output at its reset value next cycle; a new job is accepted immediately after.
- PHASES=1 build with a late core_done in IDLE -> one start per nonce; the stray done is ignored with no state change.
